imem_fetch_responder: RTL and testbench

- Instruction-memory responder for the 37-bit ISA core. It answers the 10-bit program counter's fetch address with the stored instruction and pre-decoded control-flow fields.
- Those fields are branch, is_bne, jump, immediate and jump_address, and they feed straight back into the PC block.
- It owns a 1024x37 instruction array, a program-load handshake that writes from the program load address upward, and a small run-control FSM (IDLE/LOAD/RUN/HALT).

---
 rtl/imem_pkg.sv | 26 ++
 rtl/imem_fetch_responder_if.sv | 36 +++
 rtl/imem_ctrl_decode.sv | 41 ++++
 rtl/imem_fetch_responder.sv | 189 ++++++++++++++++++
 tb/tb_imem_fetch_responder.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared opcode, field-position and run-control definitions for the instruction-memory responder.
package imem_pkg;

  localparam int ADDR_W_DEF  = 10;
  localparam int INSTR_W_DEF = 37;

  localparam logic [9:0] LOAD_BASE_DEF = 10'h200;

  localparam int OPC_HI = 36;
  localparam int OPC_LO = 31;
  localparam int IMM_HI = 15;
  localparam int JA_HI  = 25;

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Program-load handshake and fetch/decode bus between the core and the instruction-memory responder.
interface imem_fetch_responder_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 37
);

  logic               start_load;
  logic               load_valid;
  logic               load_ready;
  logic [INSTR_W-1:0] load_data;
  logic               load_last;
  logic               load_overflow;
  logic [ADDR_W-1:0]  pc;
  logic               pc_hold;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               branch;
  logic               is_bne;
  logic               jump;
  logic [15:0]        immediate;
  logic [25:0]        jump_address;
  logic               halted;

  modport master (
    output start_load, load_valid, load_data, load_last, pc,
    input  load_ready, load_overflow, pc_hold, instr, instr_valid,
           branch, is_bne, jump, immediate, jump_address, halted
  );

  modport slave (
    input  start_load, load_valid, load_data, load_last, pc,
    output load_ready, load_overflow, pc_hold, instr, instr_valid,
           branch, is_bne, jump, immediate, jump_address, halted
  );

endinterface

// File: rtl/imem_ctrl_decode.sv
// Combinational control-flow decoder: opcode and low payload of an instruction word to PC-block fields.
module imem_ctrl_decode
  import imem_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [25:0] payload,
  output logic        branch,
  output logic        is_bne,
  output logic        jump,
  output logic        is_halt,
  output logic [15:0] immediate,
  output logic [25:0] jump_address
);

  // Opcode classification; unknown opcodes decode as plain sequential instructions
  always_comb begin
    branch  = 1'b0;
    is_bne  = 1'b0;
    jump    = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      OP_BEQ:  branch  = 1'b1;
      OP_BNE: begin
        branch = 1'b1;
        is_bne = 1'b1;
      end
      OP_J:    jump    = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: begin
        branch  = 1'b0;
        is_bne  = 1'b0;
        jump    = 1'b0;
        is_halt = 1'b0;
      end
    endcase
  end

  assign immediate    = payload[IMM_HI:0];
  assign jump_address = payload[JA_HI:0];

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction memory with program-load handshake, run-control FSM and registered fetch/decode outputs.
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int               ADDR_W    = ADDR_W_DEF,
  parameter int               INSTR_W   = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] LOAD_BASE = LOAD_BASE_DEF
) (
  input  logic clk,
  input  logic reset,
  imem_fetch_responder_if.slave bus
);

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

  logic [INSTR_W-1:0] mem_r [0:DEPTH-1];

  state_t             state_r;
  state_t             state_s;
  logic [ADDR_W-1:0]  ptr_r;
  logic               exhausted_r;
  logic               overflow_r;
  logic               load_ready_s;
  logic               xfer_s;
  logic               fetch_s;

  logic [INSTR_W-1:0] rd_word_s;
  logic               dec_branch_s;
  logic               dec_is_bne_s;
  logic               dec_jump_s;
  logic               dec_halt_s;
  logic [15:0]        dec_imm_s;
  logic [25:0]        dec_jaddr_s;

  logic [INSTR_W-1:0] instr_r;
  logic               instr_valid_r;
  logic               branch_r;
  logic               is_bne_r;
  logic               jump_r;
  logic               halt_r;
  logic [15:0]        imm_r;
  logic [25:0]        jaddr_r;
  logic               pc_hold_r;
  logic               halted_r;

  assign rd_word_s = mem_r[bus.pc];

  imem_ctrl_decode u_decode (
    .opcode       (rd_word_s[OPC_HI:OPC_LO]),
    .payload      (rd_word_s[JA_HI:0]),
    .branch       (dec_branch_s),
    .is_bne       (dec_is_bne_s),
    .jump         (dec_jump_s),
    .is_halt      (dec_halt_s),
    .immediate    (dec_imm_s),
    .jump_address (dec_jaddr_s)
  );

  // Next-state and load-acceptance decode; start_load pre-empts everything, including a pending transfer
  always_comb begin
    state_s      = state_r;
    load_ready_s = 1'b0;
    if (bus.start_load) begin
      state_s = LOAD;
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        LOAD: begin
          load_ready_s = !exhausted_r;
          if (bus.load_valid && bus.load_last) begin
            state_s = RUN;
          end else begin
            state_s = LOAD;
          end
        end
        RUN: begin
          if (instr_valid_r && halt_r) begin
            state_s = HALT;
          end else begin
            state_s = RUN;
          end
        end
        HALT:    state_s = HALT;
        default: state_s = IDLE;
      endcase
    end
  end

  assign xfer_s  = bus.load_valid && load_ready_s;
  // A fetch is only presented when the core stays in RUN across the edge
  assign fetch_s = (state_r == RUN) && (state_s == RUN);

  // Run-control state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Load pointer, exhaustion flag and sticky overflow; the pointer saturates at the top address
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_r       <= LOAD_BASE;
      exhausted_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (bus.start_load) begin
      ptr_r       <= LOAD_BASE;
      exhausted_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (xfer_s) begin
        if (ptr_r == PTR_MAX) begin
          exhausted_r <= 1'b1;
        end else begin
          ptr_r <= ptr_r + ADDR_W'(1);
        end
      end
      if ((state_r == LOAD) && bus.load_valid && exhausted_r) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Instruction array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (reset && xfer_s) begin
      mem_r[ptr_r] <= bus.load_data;
    end
  end

  // Registered fetch word and decoded fields, forced to zero whenever nothing is presented
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_r       <= {INSTR_W{1'b0}};
      instr_valid_r <= 1'b0;
      branch_r      <= 1'b0;
      is_bne_r      <= 1'b0;
      jump_r        <= 1'b0;
      halt_r        <= 1'b0;
      imm_r         <= 16'h0000;
      jaddr_r       <= 26'h0000000;
    end else if (fetch_s) begin
      instr_r       <= rd_word_s;
      instr_valid_r <= 1'b1;
      branch_r      <= dec_branch_s;
      is_bne_r      <= dec_is_bne_s;
      jump_r        <= dec_jump_s;
      halt_r        <= dec_halt_s;
      imm_r         <= dec_imm_s;
      jaddr_r       <= dec_jaddr_s;
    end else begin
      instr_r       <= {INSTR_W{1'b0}};
      instr_valid_r <= 1'b0;
      branch_r      <= 1'b0;
      is_bne_r      <= 1'b0;
      jump_r        <= 1'b0;
      halt_r        <= 1'b0;
      imm_r         <= 16'h0000;
      jaddr_r       <= 26'h0000000;
    end
  end

  // Status flags registered from the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_hold_r <= 1'b1;
      halted_r  <= 1'b0;
    end else begin
      pc_hold_r <= (state_s != RUN);
      halted_r  <= (state_s == HALT);
    end
  end

  assign bus.load_ready    = load_ready_s;
  assign bus.load_overflow = overflow_r;
  assign bus.pc_hold       = pc_hold_r;
  assign bus.halted        = halted_r;
  assign bus.instr         = instr_r;
  assign bus.instr_valid   = instr_valid_r;
  assign bus.branch        = branch_r;
  assign bus.is_bne        = is_bne_r;
  assign bus.jump          = jump_r;
  assign bus.immediate     = imm_r;
  assign bus.jump_address  = jaddr_r;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Randomized self-checking bench for imem_fetch_responder against a cycle-level behavioural model.
module tb_imem_fetch_responder;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;
  localparam int M_HALT = 3;

  logic clk;
  logic reset;

  imem_fetch_responder_if bus ();

  imem_fetch_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] mmem [0:1023];
  int          mstate;
  int          mptr;
  bit          movf;
  bit          mvalid;
  logic [36:0] minstr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic post_check();
    logic [5:0] opc;
    opc = minstr[36:31];
    check("pc_hold", 64'(bus.pc_hold), 64'(mstate != M_RUN));
    check("halted", 64'(bus.halted), 64'(mstate == M_HALT));
    check("load_overflow", 64'(bus.load_overflow), 64'(movf));
    check("instr_valid", 64'(bus.instr_valid), 64'(mvalid));
    if (mvalid) begin
      check("instr", 64'(bus.instr), 64'(minstr));
    end else begin
      check("instr_idle", 64'(bus.instr), 64'h0);
    end
    check("branch", 64'(bus.branch), 64'(mvalid && (opc == 6'h04 || opc == 6'h05)));
    check("is_bne", 64'(bus.is_bne), 64'(mvalid && (opc == 6'h05)));
    check("jump", 64'(bus.jump), 64'(mvalid && (opc == 6'h02)));
    check("immediate", 64'(bus.immediate), mvalid ? 64'(minstr[15:0]) : 64'h0);
    check("jump_address", 64'(bus.jump_address), mvalid ? 64'(minstr[25:0]) : 64'h0);
  endtask

  // One clock of stimulus; the model advances by the behavioural rules and all outputs are compared.
  task automatic cyc(input bit sl, input bit lv, input logic [36:0] ld, input bit ll, input logic [9:0] pa);
    bus.start_load = sl;
    bus.load_valid = lv;
    bus.load_data  = ld;
    bus.load_last  = ll;
    bus.pc         = pa;
    #1;
    check("load_ready", 64'(bus.load_ready), 64'(mstate == M_LOAD && mptr < 1024 && !sl));
    @(posedge clk);
    if (sl) begin
      mstate = M_LOAD;
      mptr   = 32'h200;
      movf   = 1'b0;
      mvalid = 1'b0;
    end else begin
      case (mstate)
        M_LOAD: begin
          if (lv) begin
            if (mptr < 1024) begin
              mmem[mptr] = ld;
              mptr       = mptr + 1;
            end else begin
              movf = 1'b1;
            end
            if (ll) mstate = M_RUN;
          end
          mvalid = 1'b0;
        end
        M_RUN: begin
          if (mvalid && minstr[36:31] == 6'h3F) begin
            mstate = M_HALT;
            mvalid = 1'b0;
          end else begin
            minstr = mmem[pa];
            mvalid = 1'b1;
          end
        end
        default: mvalid = 1'b0;
      endcase
    end
    #1;
    post_check();
  endtask

  task automatic do_reset();
    bus.start_load = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    reset          = 1'b0;
    @(posedge clk);
    mstate = M_IDLE;
    mptr   = 32'h200;
    movf   = 1'b0;
    mvalid = 1'b0;
    #1;
    reset = 1'b1;
    post_check();
    check("reset_load_ready", 64'(bus.load_ready), 64'h0);
  endtask

  function automatic logic [36:0] gen_word();
    logic [5:0]  o;
    logic [30:0] b;
    case ($urandom_range(0, 3))
      0:       o = 6'h02;
      1:       o = 6'h04;
      2:       o = 6'h05;
      default: begin
        o = 6'($urandom);
        if (o == 6'h3F) o = 6'h00;
      end
    endcase
    b = 31'($urandom);
    return {o, b};
  endfunction

  task automatic start();
    cyc(1'b1, 1'b0, 37'h0, 1'b0, 10'h200);
  endtask

  task automatic load_rand(input int n, input bit last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) cyc(1'b0, 1'b0, 37'h0, 1'b0, 10'h200);
      end
      cyc(1'b0, 1'b1, gen_word(), last && (i == n - 1), 10'h200);
    end
  endtask

  task automatic fetch(input logic [9:0] a);
    cyc(1'b0, 1'b0, 37'h0, 1'b0, a);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mmem[i] = 37'h0;
    minstr         = 37'h0;
    bus.start_load = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 37'h0;
    bus.load_last  = 1'b0;
    bus.pc         = 10'h200;
    reset          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Directed BEQ / BNE / HALT program
    start();
    cyc(1'b0, 1'b1, {6'h04, 15'h0, 16'h0004}, 1'b0, 10'h200);
    cyc(1'b0, 1'b1, {6'h05, 15'h0, 16'hFFFE}, 1'b0, 10'h200);
    cyc(1'b0, 1'b1, {6'h3F, 31'h0}, 1'b1, 10'h200);
    check("run_reached", 64'(bus.pc_hold), 64'h0);
    fetch(10'h200);
    check("beq_branch", 64'(bus.branch), 64'h1);
    check("beq_imm", 64'(bus.immediate), 64'h0004);
    fetch(10'h201);
    check("bne_flag", 64'(bus.is_bne), 64'h1);
    fetch(10'h202);
    fetch(10'h200);
    check("halt_seen", 64'(bus.halted), 64'h1);
    fetch(10'h200);

    // Jump word
    start();
    cyc(1'b0, 1'b1, {6'h02, 5'h0, 26'h00003FF}, 1'b0, 10'h200);
    load_rand(2, 1'b1, 1'b1);
    fetch(10'h200);
    check("j_jump", 64'(bus.jump), 64'h1);
    check("j_addr", 64'(bus.jump_address), 64'h3FF);
    for (int i = 0; i < 6; i++) fetch(10'h200 + 10'($urandom_range(0, 2)));

    // Randomized programs with gaps in load_valid
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 24);
      start();
      load_rand(n, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) fetch(10'h200 + 10'($urandom_range(0, n - 1)));
    end

    // Fill to the top of the array, then overflow
    start();
    load_rand(512, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, gen_word(), 1'b0, 10'h200);
    check("ovf_set", 64'(bus.load_overflow), 64'h1);
    cyc(1'b0, 1'b1, gen_word(), 1'b1, 10'h200);
    fetch(10'h200);
    fetch(10'h3FF);
    fetch(10'h2A5);

    // start_load in RUN together with a pending fetch
    cyc(1'b1, 1'b0, 37'h0, 1'b0, 10'h201);
    check("restart_valid", 64'(bus.instr_valid), 64'h0);
    load_rand(1, 1'b1, 1'b0);
    fetch(10'h200);
    fetch(10'h201);

    // start_load colliding with a load transfer drops that word
    start();
    load_rand(2, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, gen_word(), 1'b0, 10'h200);
    load_rand(1, 1'b1, 1'b0);
    fetch(10'h200);
    fetch(10'h201);

    // Reset in the middle of a load
    start();
    load_rand(2, 1'b0, 1'b0);
    do_reset();
    cyc(1'b0, 1'b0, 37'h0, 1'b0, 10'h200);
    start();
    load_rand(1, 1'b1, 1'b0);
    fetch(10'h200);
    fetch(10'h201);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
